// File: rtl/jtcop_pkg.sv
// Shared constants for the object line buffer: default address/pixel widths
// and the width of the colour-index field that decides transparency.
// No ports; imported by jtcop_objbuf and jtcop_objbuf_bank.
package jtcop_pkg;

  localparam int OBJ_AW   = 9;  // pixel positions per line = 2**OBJ_AW
  localparam int OBJ_DW   = 8;  // pixel width: [3:0] colour, upper bits palette/priority
  localparam int TRANSP_W = 4;  // colour index 0 means transparent

  function automatic logic is_opaque(input logic [TRANSP_W-1:0] colour);
    return colour != '0;
  endfunction

endpackage

// File: rtl/jtcop_objbuf_bank.sv
// One line bank: 2^AW x DW dual-port RAM. Port A is the draw-engine write port,
// port B is the display port (synchronous read, or write-to-zero for clear).
// Ports: clk; i_a_we/i_a_addr/i_a_dat (draw write); i_b_re/i_b_we/i_b_addr (display), o_b_q (read data).
module jtcop_objbuf_bank
  import jtcop_pkg::*;
#(
  parameter int AW = OBJ_AW,
  parameter int DW = OBJ_DW
) (
  input  logic          clk,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_dat,
  input  logic          i_b_re,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  output logic [DW-1:0] o_b_q
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_dat;
    if (i_b_we) r_mem[i_b_addr] <= '0;
    if (i_b_re) o_b_q <= r_mem[i_b_addr];
  end

endmodule

// File: rtl/jtcop_objbuf.sv
// Double-buffered object line buffer: the draw engine fills one bank while the
// other is scanned out (and cleared behind the read) for the colour mixer.
// Ports: clk, rst_n, pxl_cen, LHBL, flip, buf_we/buf_addr/buf_data (draw) -> swap, bank, obj_pxl.
// Optional feature: define JTCOP_OBJBUF_FLIP_EN to let flip reverse the read address.
module jtcop_objbuf
  import jtcop_pkg::*;
#(
  parameter int AW = OBJ_AW,
  parameter int DW = OBJ_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          flip,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  output logic          swap,
  output logic          bank,
  output logic [DW-1:0] obj_pxl
);

  logic          r_lhbl, r_lhbl_l;
  logic          r_bank;
  logic          r_act;       // a line has started since reset; reads allowed
  logic [AW-1:0] r_cnt;
  logic          r_rd_vld, r_rd_bank;
  logic          r_clr, r_clr_bank;
  logic [AW-1:0] r_clr_addr;
  logic [DW-1:0] r_obj_pxl;

  logic          w_fall, w_rise, w_rd, w_we;
  logic [AW-1:0] w_cnt, w_rd_addr, w_b_addr;
  logic [DW-1:0] w_q [2];
  logic [DW-1:0] w_rd_q;

  // LHBL is registered once so both edges are seen against registered state;
  // swap is high while the draw bank is still the pre-swap one, so a write in
  // that clk still lands in the bank about to be displayed.
  assign w_fall = r_lhbl_l & ~r_lhbl;
  assign w_rise = ~r_lhbl_l & r_lhbl;
  assign w_cnt  = w_rise ? '0 : r_cnt;
  assign w_rd   = pxl_cen & r_lhbl & (r_act | w_rise);
  assign w_we   = buf_we & is_opaque(buf_data[TRANSP_W-1:0]);

`ifdef JTCOP_OBJBUF_FLIP_EN
  assign w_rd_addr = flip ? ~w_cnt : w_cnt;
`else
  logic w_unused_flip;
  assign w_unused_flip = flip;
  assign w_rd_addr = w_cnt;
`endif

  // pxl_cen pulses are >= 2 clk apart, so a clear never meets a read.
  assign w_b_addr = r_clr ? r_clr_addr : w_rd_addr;
  assign w_rd_q   = w_q[r_rd_bank];

  for (genvar i = 0; i < 2; i++) begin : g_bank
    localparam logic SEL = 1'(i);
    jtcop_objbuf_bank #(.AW(AW), .DW(DW)) u_bank (
      .clk      (clk),
      .i_a_we   (w_we && (r_bank == SEL)),
      .i_a_addr (buf_addr),
      .i_a_dat  (buf_data),
      .i_b_re   (w_rd && (r_bank != SEL)),
      .i_b_we   (r_clr && (r_clr_bank == SEL)),
      .i_b_addr (w_b_addr),
      .o_b_q    (w_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lhbl     <= 1'b1;
      r_lhbl_l   <= 1'b1;
      r_bank     <= 1'b0;
      r_act      <= 1'b0;
      r_cnt      <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_clr      <= 1'b0;
      r_clr_bank <= 1'b0;
      r_clr_addr <= '0;
      r_obj_pxl  <= '0;
    end else begin
      r_lhbl   <= LHBL;
      r_lhbl_l <= r_lhbl;
      if (w_fall) r_bank <= ~r_bank;
      if (w_rise) begin
        r_act <= 1'b1;
        r_cnt <= '0;
      end
      r_clr <= w_rd;
      if (w_rd) begin
        r_cnt      <= w_cnt + AW'(1);
        r_clr_addr <= w_rd_addr;
        r_clr_bank <= ~r_bank;
        r_rd_bank  <= ~r_bank;
      end
      // Output the previous read; the first pixel of a line has none yet.
      if (pxl_cen) begin
        r_obj_pxl <= (r_lhbl && r_rd_vld && !w_rise) ? w_rd_q : '0;
        r_rd_vld  <= w_rd;
      end else if (w_rise) begin
        r_rd_vld  <= 1'b0;
      end
    end
  end

  assign swap    = w_fall;
  assign bank    = r_bank;
  assign obj_pxl = r_obj_pxl;

endmodule

// File: tb/tb_jtcop_objbuf.sv
module tb_jtcop_objbuf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic       flip = 1'b0;
  logic       buf_we = 1'b0;
  logic [8:0] buf_addr = '0;
  logic [7:0] buf_data = '0;
  logic       swap, bank;
  logic [7:0] obj_pxl;

  jtcop_objbuf #(.AW(9), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .flip(flip),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .swap(swap), .bank(bank), .obj_pxl(obj_pxl)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       exp_bank = 1'b0;
  logic [7:0] cap [0:512];

  typedef struct {
    logic [8:0] addr;
    logic [7:0] dat;
    logic [7:0] exp;
    int         nz;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(output logic [7:0] v);
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    v = obj_pxl;
    tick();
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    buf_we = 1'b1; buf_addr = a; buf_data = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic run_line(input int npx);
    logic [7:0] v;
    LHBL = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < npx; i++) begin
      pixel(v);
      cap[i] = v;
    end
  endtask

  task automatic blank();
    int nsw;
    logic [7:0] v;
    nsw = 0;
    LHBL = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nsw += int'(swap);
    end
    exp_bank = ~exp_bank;
    check("swap_pulse", nsw, 1);
    check("bank_after_swap", int'(bank), int'(exp_bank));
    pixel(v);
    check("blank_pxl", int'(v), 0);
  endtask

  function automatic int count_nz();
    int n = 0;
    for (int i = 0; i < 513; i++) if (cap[i] != 8'h00) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic [7:0] v;

    vecs[0] = '{9'd10,  8'h35, 8'h35, 1};
    vecs[1] = '{9'd0,   8'h01, 8'h01, 1};
    vecs[2] = '{9'd511, 8'hF7, 8'hF7, 1};
    vecs[3] = '{9'd200, 8'h30, 8'h00, 0};
    vecs[4] = '{9'd100, 8'h0F, 8'h0F, 1};
    vecs[5] = '{9'd300, 8'hA0, 8'h00, 0};
    vecs[6] = '{9'd256, 8'h8C, 8'h8C, 1};

    // Reset state
    repeat (3) tick();
    check("rst_bank", int'(bank), 0);
    check("rst_swap", int'(swap), 0);
    check("rst_obj_pxl", int'(obj_pxl), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Two full lines scrub both banks through clear-on-read
    blank(); run_line(513);
    blank(); run_line(513);

    // Table: one write into the draw bank, show it on the next line
    for (int r = 0; r < 7; r++) begin
      wr(vecs[r].addr, vecs[r].dat);
      blank();
      run_line(513);
      check($sformatf("vec%0d_pxl", r), int'(cap[int'(vecs[r].addr) + 1]), int'(vecs[r].exp));
      check($sformatf("vec%0d_nz", r), count_nz(), vecs[r].nz);
    end

    // Transparent write keeps old pixel; opaque overwrite wins
    wr(9'd10, 8'h35); wr(9'd10, 8'h30);
    wr(9'd20, 8'h35); wr(9'd20, 8'h46);
    blank(); run_line(513);
    check("transp_keep", int'(cap[11]), 8'h35);
    check("last_writer", int'(cap[21]), 8'h46);
    check("transp_nz", count_nz(), 2);

    // Both banks empty after being displayed once
    blank(); run_line(513);
    check("clear_other_nz", count_nz(), 0);
    blank(); run_line(513);
    check("clear_same_nz", count_nz(), 0);

    // Flip
    wr(9'd0, 8'h12);
    flip = 1'b1;
    blank(); run_line(513);
    flip = 1'b0;
`ifdef JTCOP_OBJBUF_FLIP_EN
    idx = 512;
`else
    idx = 1;
`endif
    check("flip_pxl", int'(cap[idx]), 8'h12);
    check("flip_nz", count_nz(), 1);

    // Writes at the LHBL fall and during the swap clk hit the pre-swap bank;
    // the write one clk later hits the new draw bank.
    LHBL = 1'b0;
    buf_we = 1'b1; buf_addr = 9'd50; buf_data = 8'h47;
    tick();
    check("swap_at_fall_wr", int'(swap), 1);
    buf_addr = 9'd60; buf_data = 8'h58;
    tick();
    buf_addr = 9'd70; buf_data = 8'h69;
    tick();
    buf_we = 1'b0;
    exp_bank = ~exp_bank;
    check("bank_edge_wr", int'(bank), int'(exp_bank));
    pixel(v);
    run_line(513);
    check("edge_wr_fall", int'(cap[51]), 8'h47);
    check("edge_wr_swap", int'(cap[61]), 8'h58);
    check("edge_wr_late_absent", int'(cap[71]), 0);
    check("edge_wr_nz", count_nz(), 2);
    blank(); run_line(513);
    check("edge_wr_late", int'(cap[71]), 8'h69);
    check("edge_wr_late_nz", count_nz(), 1);

    // Reset mid-line at pixel 100
    wr(9'd5, 8'h77);
    blank();
    run_line(100);
    check("pre_rst_bank", int'(bank), int'(exp_bank));
    rst_n = 1'b0;
    #1;
    check("midrst_obj_pxl", int'(obj_pxl), 0);
    check("midrst_bank", int'(bank), 0);
    check("midrst_swap", int'(swap), 0);
    exp_bank = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      pixel(v);
      check($sformatf("post_rst_pxl%0d", i), int'(v), 0);
    end
    blank();
    check("post_rst_bank", int'(bank), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtcop_objbuf.md
JTCOP_OBJBUF -- requirements
Module: jtcop_objbuf

Interface
REQ-001 Parameter AW, 9: line buffer address width (pixel positions per line = 2^AW).
REQ-002 Parameter DW, 8: pixel width (bits [3:0] colour index, bits [DW-1:4] palette/priority).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 pxl_cen  in  1  pixel clock enable; successive pulses at least 2 clk apart.
REQ-006 LHBL  in  1  horizontal blank, active low.
REQ-007 flip  in  1  horizontal read reversal.
REQ-008 buf_we  in  1  draw-engine pixel write strobe.
REQ-009 buf_addr  in  AW  draw-engine pixel x position.
REQ-010 buf_data  in  DW  draw-engine pixel value.
REQ-011 swap  out  1  one-clk pulse when the banks exchange.
REQ-012 bank  out  1  index of the bank currently owned by the draw engine.
REQ-013 obj_pxl  out  DW  pixel delivered to the colour mixer's obj_pxl input.

Function
REQ-014 SHALL hold two line banks of 2^AW x DW: one draw bank (writes) and one display bank (reads).
REQ-015 SHALL detect the LHBL falling edge (start of hblank), toggle bank, and pulse swap for exactly one clk.
REQ-016 A write in the same clk as the swap SHALL land in the pre-swap draw bank.
REQ-017 Draw writes SHALL be performed only when buf_we=1 and buf_data[3:0]!=0; transparent pixels leave memory untouched.
- Opaque writes overwrite unconditionally; the last writer wins.
REQ-018 Display read counter SHALL reset to 0 on the LHBL rising edge and increment by 1 on each pxl_cen while LHBL=1.
- The counter wraps modulo 2^AW.
REQ-019 Read address SHALL be the counter, or ~counter when flip=1 (subject to REQ-028).
REQ-020 On each pxl_cen, obj_pxl SHALL load the value read at the previous pxl_cen (one-pixel latency).
- obj_pxl is registered and changes only on pxl_cen.
REQ-021 In the clk after each display read, that location SHALL be written to 0, leaving the bank clear for its next draw turn.
REQ-022 While LHBL=0, obj_pxl SHALL be forced to 0 at pxl_cen, and no reads or clears occur.
REQ-023 The display side SHALL never write the draw bank, and the draw side SHALL never write the display bank; there are no port collisions.

Reset
REQ-024 While rst_n=0: bank=0, swap=0, obj_pxl=0, read counter=0, edge detectors preset to LHBL=1.
REQ-025 Reset asserted mid-line SHALL abort the line; after release, operation resumes at the next LHBL edge.
- RAM contents are not reset.

Configuration
REQ-026 Macro JTCOP_OBJBUF_FLIP_EN controls support for the flip input.
REQ-027 With JTCOP_OBJBUF_FLIP_EN defined, flip SHALL select the read address per REQ-019.
REQ-028 Without JTCOP_OBJBUF_FLIP_EN, flip SHALL be ignored and the read address is always the counter.

Structure
REQ-029 The shared package jtcop_pkg SHALL hold the AW/DW defaults and the transparency-test width constant (4).
REQ-030 One sub-module jtcop_objbuf_bank (a dual-port RAM instantiated twice, selected by bank) SHALL be used; all control logic remains in jtcop_objbuf.

Verification
REQ-031 Write 0x35 at x=10 in bank 0, swap, read the line -> obj_pxl=0x35 at pixel 11 (one-pixel latency), 0 elsewhere.
REQ-032 Write 0x30 (transparent) over an existing 0x35 at x=10 -> 0x35 is still displayed.
REQ-033 Display a line, then swap twice and display the same bank without writes -> all obj_pxl=0, confirming clear-on-read.
REQ-034 With the macro defined and flip=1, write 0x12 at x=0 -> 0x12 appears at counter 511; with the macro undefined -> 0x12 appears at counter 0.
REQ-035 Pulse buf_we in the same clk as the LHBL falling edge -> data appears in the bank displayed on the following line.
REQ-036 Assert rst_n=0 at pixel 100 -> obj_pxl=0, bank=0 immediately; after release, the next LHBL fall -> swap pulse and bank=1.
